// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the MEM-stage CPU access and an aux (DMA/debug) requester.
// Optional misalignment trap enabled by defining DMEM_ARB_ERR_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Cpu_Req,
  input  logic              i_Cpu_Write,
  input  logic [1:0]        i_Cpu_Width,
  input  logic [ADDR_W-1:0] i_Cpu_Addr,
  input  logic [DATA_W-1:0] i_Cpu_WData,
  output logic              o_Cpu_Stall,
  output logic [DATA_W-1:0] o_Cpu_RData,
  output logic              o_Cpu_Err,
  input  logic              i_Aux_Req,
  input  logic              i_Aux_Write,
  input  logic [1:0]        i_Aux_Width,
  input  logic [ADDR_W-1:0] i_Aux_Addr,
  input  logic [DATA_W-1:0] i_Aux_WData,
  output logic              o_Aux_Done,
  output logic [DATA_W-1:0] o_Aux_RData,
  output logic              o_Aux_Err,
  output logic              o_Mem_R_Enable,
  output logic              o_Mem_W_Enable,
  output logic [1:0]        o_Mem_R_Width,
  output logic [1:0]        o_Mem_W_Width,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic [DATA_W-1:0] i_Mem_RData
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int   CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int   AW_W    = $clog2(AUX_MAX_WAIT + 1);
  localparam logic OWN_AUX = 1'b1;

  state_t            r_state;
  logic              r_owner;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [AW_W-1:0]   r_aux_wait;
  logic              r_cpu_done;
  logic              r_aux_done;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_aux_rdata;
  logic              r_cpu_err;
  logic              r_aux_err;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [1:0]        r_mem_rwidth;
  logic [1:0]        r_mem_wwidth;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_any_req;
  logic              w_aux_win;
  logic              w_sel_write;
  logic [1:0]        w_sel_width;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_misaligned;

  // CPU wins ties unless aux has lost AUX_MAX_WAIT arbitrations in a row.
  assign w_any_req   = i_Cpu_Req | i_Aux_Req;
  assign w_aux_win   = i_Aux_Req & (~i_Cpu_Req | (r_aux_wait == AW_W'(AUX_MAX_WAIT)));
  assign w_sel_write = w_aux_win ? i_Aux_Write : i_Cpu_Write;
  assign w_sel_width = w_aux_win ? i_Aux_Width : i_Cpu_Width;
  assign w_sel_addr  = w_aux_win ? i_Aux_Addr  : i_Cpu_Addr;
  assign w_sel_wdata = w_aux_win ? i_Aux_WData : i_Cpu_WData;

`ifdef DMEM_ARB_ERR_EN
  assign w_misaligned = ((w_sel_width == 2'b00) & (w_sel_addr[1:0] != 2'b00)) |
                        ((w_sel_width == 2'b01) & w_sel_addr[0]);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_wait_cnt   <= '0;
      r_aux_wait   <= '0;
      r_cpu_done   <= 1'b0;
      r_aux_done   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_aux_rdata  <= '0;
      r_cpu_err    <= 1'b0;
      r_aux_err    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_rwidth <= 2'b00;
      r_mem_wwidth <= 2'b00;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_aux_win;
            if (w_aux_win)
              r_aux_wait <= '0;
            else if (i_Aux_Req && (r_aux_wait != AW_W'(AUX_MAX_WAIT)))
              r_aux_wait <= r_aux_wait + AW_W'(1);
            if (w_misaligned) begin
              // Trapped access: straight to DONE, memory never strobed.
              r_state    <= S_DONE;
              r_cpu_done <= ~w_aux_win;
              r_aux_done <= w_aux_win;
              r_cpu_err  <= ~w_aux_win;
              r_aux_err  <= w_aux_win;
            end else begin
              r_state      <= S_ISSUE;
              r_mem_ren    <= ~w_sel_write;
              r_mem_wen    <= w_sel_write;
              r_mem_rwidth <= w_sel_write ? 2'b00 : w_sel_width;
              r_mem_wwidth <= w_sel_write ? w_sel_width : 2'b00;
              r_mem_addr   <= w_sel_addr;
              r_mem_wdata  <= w_sel_write ? w_sel_wdata : '0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_ren    <= 1'b0;
          r_mem_wen    <= 1'b0;
          r_mem_rwidth <= 2'b00;
          r_mem_wwidth <= 2'b00;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          if (r_mem_wen) begin
            r_state    <= S_DONE;
            r_cpu_done <= (r_owner != OWN_AUX);
            r_aux_done <= (r_owner == OWN_AUX);
          end else begin
            r_state    <= S_WAIT;
            r_wait_cnt <= CNT_W'(MEM_LAT - 1);
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state     <= S_DONE;
            r_cpu_done  <= (r_owner != OWN_AUX);
            r_aux_done  <= (r_owner == OWN_AUX);
            r_cpu_rdata <= (r_owner == OWN_AUX) ? '0 : i_Mem_RData;
            r_aux_rdata <= (r_owner == OWN_AUX) ? i_Mem_RData : '0;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cpu_done  <= 1'b0;
          r_aux_done  <= 1'b0;
          r_cpu_rdata <= '0;
          r_aux_rdata <= '0;
          r_cpu_err   <= 1'b0;
          r_aux_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the MEM stage freezes in the same cycle it raises a request.
  assign o_Cpu_Stall    = i_Cpu_Req & ~r_cpu_done;
  assign o_Cpu_RData    = r_cpu_rdata;
  assign o_Cpu_Err      = r_cpu_err;
  assign o_Aux_Done     = r_aux_done;
  assign o_Aux_RData    = r_aux_rdata;
  assign o_Aux_Err      = r_aux_err;
  assign o_Mem_R_Enable = r_mem_ren;
  assign o_Mem_W_Enable = r_mem_wen;
  assign o_Mem_R_Width  = r_mem_rwidth;
  assign o_Mem_W_Width  = r_mem_wwidth;
  assign o_Mem_Addr     = r_mem_addr;
  assign o_Mem_WData    = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3 for latency and mid-access reset.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A (MEM_LAT=1)
  logic        rst_n, cpu_req, cpu_write, aux_req, aux_write;
  logic [1:0]  cpu_width, aux_width;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata, mem_rdata;
  logic        cpu_stall, cpu_err, aux_done, aux_err, mem_ren, mem_wen;
  logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_rwidth, mem_wwidth;

  // Instance B (MEM_LAT=3)
  logic        b_rst_n, b_cpu_req, b_cpu_write, b_aux_req, b_aux_write;
  logic [1:0]  b_cpu_width, b_aux_width;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_aux_addr, b_aux_wdata, b_mem_rdata;
  logic        b_cpu_stall, b_cpu_err, b_aux_done, b_aux_err, b_mem_ren, b_mem_wen;
  logic [31:0] b_cpu_rdata, b_aux_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_mem_rwidth, b_mem_wwidth;

  // Expected owner of each grant while both request continuously (1 = aux)
  logic exp_aux [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .AUX_MAX_WAIT(4)) u_dut (
    .i_Clock(clk), .i_Reset(rst_n),
    .i_Cpu_Req(cpu_req), .i_Cpu_Write(cpu_write), .i_Cpu_Width(cpu_width),
    .i_Cpu_Addr(cpu_addr), .i_Cpu_WData(cpu_wdata),
    .o_Cpu_Stall(cpu_stall), .o_Cpu_RData(cpu_rdata), .o_Cpu_Err(cpu_err),
    .i_Aux_Req(aux_req), .i_Aux_Write(aux_write), .i_Aux_Width(aux_width),
    .i_Aux_Addr(aux_addr), .i_Aux_WData(aux_wdata),
    .o_Aux_Done(aux_done), .o_Aux_RData(aux_rdata), .o_Aux_Err(aux_err),
    .o_Mem_R_Enable(mem_ren), .o_Mem_W_Enable(mem_wen),
    .o_Mem_R_Width(mem_rwidth), .o_Mem_W_Width(mem_wwidth),
    .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata), .i_Mem_RData(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .AUX_MAX_WAIT(4)) u_dut3 (
    .i_Clock(clk), .i_Reset(b_rst_n),
    .i_Cpu_Req(b_cpu_req), .i_Cpu_Write(b_cpu_write), .i_Cpu_Width(b_cpu_width),
    .i_Cpu_Addr(b_cpu_addr), .i_Cpu_WData(b_cpu_wdata),
    .o_Cpu_Stall(b_cpu_stall), .o_Cpu_RData(b_cpu_rdata), .o_Cpu_Err(b_cpu_err),
    .i_Aux_Req(b_aux_req), .i_Aux_Write(b_aux_write), .i_Aux_Width(b_aux_width),
    .i_Aux_Addr(b_aux_addr), .i_Aux_WData(b_aux_wdata),
    .o_Aux_Done(b_aux_done), .o_Aux_RData(b_aux_rdata), .o_Aux_Err(b_aux_err),
    .o_Mem_R_Enable(b_mem_ren), .o_Mem_W_Enable(b_mem_wen),
    .o_Mem_R_Width(b_mem_rwidth), .o_Mem_W_Width(b_mem_wwidth),
    .o_Mem_Addr(b_mem_addr), .o_Mem_WData(b_mem_wdata), .i_Mem_RData(b_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enter the next cycle just after the rising edge, then sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int grants;
    int aux_dones;
    int cnt;

    rst_n = 1'b0; cpu_req = 1'b1; cpu_write = 1'b1; cpu_width = 2'b00;
    cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    aux_req = 1'b1; aux_write = 1'b0; aux_width = 2'b00;
    aux_addr = 32'h40; aux_wdata = 32'h0; mem_rdata = 32'hBAD0BAD0;
    b_rst_n = 1'b0; b_cpu_req = 1'b0; b_cpu_write = 1'b0; b_cpu_width = 2'b00;
    b_cpu_addr = 32'h0; b_cpu_wdata = 32'h0;
    b_aux_req = 1'b0; b_aux_write = 1'b0; b_aux_width = 2'b00;
    b_aux_addr = 32'h0; b_aux_wdata = 32'h0; b_mem_rdata = 32'hBAD0BAD0;

    // Reset held over two edges with both requesting
    cyc(); mid();
    check("rst1_ren", mem_ren, 0);   check("rst1_wen", mem_wen, 0);
    check("rst1_auxdone", aux_done, 0); check("rst1_stall", cpu_stall, 1);
    check("rst1_addr", mem_addr, 0); check("rst1_cpurdata", cpu_rdata, 0);
    cyc();
    rst_n = 1'b1; b_rst_n = 1'b1;
    mid();
    // Cycle 0 of CPU store word
    check("st_c0_stall", cpu_stall, 1); check("st_c0_wen", mem_wen, 0);
    cyc(); mid();
    check("st_c1_wen", mem_wen, 1); check("st_c1_ren", mem_ren, 0);
    check("st_c1_addr", mem_addr, 32'h10); check("st_c1_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_c1_wwidth", mem_wwidth, 2'b00); check("st_c1_stall", cpu_stall, 1);
    cyc(); mid();
    check("st_c2_stall", cpu_stall, 0); check("st_c2_wen", mem_wen, 0);
    check("st_c2_auxdone", aux_done, 0);
    cpu_write = 1'b0; cpu_width = 2'b10; cpu_addr = 32'h21; cpu_wdata = 32'h0;

    // CPU load byte @0x21, aux still requesting and losing
    cyc(); mid();
    check("ld_c0_stall", cpu_stall, 1); check("ld_c0_ren", mem_ren, 0);
    cyc(); mid();
    check("ld_c1_ren", mem_ren, 1); check("ld_c1_rwidth", mem_rwidth, 2'b10);
    check("ld_c1_addr", mem_addr, 32'h21); check("ld_c1_wen", mem_wen, 0);
    cyc();
    mem_rdata = 32'h12345678;
    mid();
    check("ld_c2_stall", cpu_stall, 1); check("ld_c2_ren", mem_ren, 0);
    cyc();
    mem_rdata = 32'hCAFEF00D;
    mid();
    check("ld_c3_stall", cpu_stall, 0); check("ld_c3_rdata", cpu_rdata, 32'h12345678);
    cpu_write = 1'b1; cpu_width = 2'b00; cpu_addr = 32'h10; cpu_wdata = 32'h11111111;

    // Both requesting continuously: aux forced through after four losses
    grants = 0; aux_dones = 0; cnt = 0;
    while (cnt < 60 && !(grants == 8 && aux_dones == 2)) begin
      cyc(); mid(); cnt++;
      if (mem_ren || mem_wen) begin
        if (grants < 8) begin
          check($sformatf("grant%0d_owner", grants), mem_ren, exp_aux[grants]);
          check($sformatf("grant%0d_addr", grants), mem_addr, exp_aux[grants] ? 32'h40 : 32'h10);
        end
        grants++;
        if (grants == 8) cpu_req = 1'b0;
      end
      if (aux_done) begin
        check("starve_aux_rdata", aux_rdata, 32'hCAFEF00D);
        check("starve_stall", cpu_stall, cpu_req);
        aux_dones++;
        if (grants == 8) aux_req = 1'b0;
      end
    end
    check("starve_grants", grants, 8);
    check("starve_aux_dones", aux_dones, 2);

    // Misaligned CPU word load @0x2
    cyc();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_width = 2'b00; cpu_addr = 32'h2;
    mem_rdata = 32'h0BADF00D;
    mid();
    check("mis_c0_stall", cpu_stall, 1); check("mis_c0_ren", mem_ren, 0);
`ifdef DMEM_ARB_ERR_EN
    cyc(); mid();
    check("mis_c1_err", cpu_err, 1); check("mis_c1_stall", cpu_stall, 0);
    check("mis_c1_rdata", cpu_rdata, 0); check("mis_c1_ren", mem_ren, 0);
    cpu_req = 1'b0;
`else
    cyc(); mid();
    check("mis_c1_ren", mem_ren, 1); check("mis_c1_addr", mem_addr, 32'h2);
    check("mis_c1_err", cpu_err, 0);
    cyc(); mid();
    check("mis_c2_stall", cpu_stall, 1);
    cyc(); mid();
    check("mis_c3_stall", cpu_stall, 0); check("mis_c3_rdata", cpu_rdata, 32'h0BADF00D);
    check("mis_c3_err", cpu_err, 0);
    cpu_req = 1'b0;
`endif
    cyc(); mid();
    check("post_mis_ren", mem_ren, 0); check("post_mis_err", cpu_err, 0);

    // Instance B: aux load with MEM_LAT=3, read DONE in cycle 5
    cyc();
    b_aux_req = 1'b1; b_aux_addr = 32'h80;
    mid();
    check("b_c0_stall", b_cpu_stall, 0);
    cyc(); mid();
    check("b_c1_ren", b_mem_ren, 1); check("b_c1_addr", b_mem_addr, 32'h80);
    cyc(); mid();
    check("b_c2_ren", b_mem_ren, 0);
    cyc(); mid();
    check("b_c3_auxdone", b_aux_done, 0);
    cyc();
    b_mem_rdata = 32'h5A5A5A5A;
    mid();
    check("b_c4_auxdone", b_aux_done, 0);
    cyc();
    b_mem_rdata = 32'hBAD0BAD0;
    mid();
    check("b_c5_auxdone", b_aux_done, 1); check("b_c5_rdata", b_aux_rdata, 32'h5A5A5A5A);
    check("b_c5_err", b_aux_err, 0);
    // New aux load, then reset for one cycle while in WAIT
    cyc();
    b_aux_addr = 32'h84;
    mid();
    check("b_n0_auxdone", b_aux_done, 0); check("b_n0_rdata", b_aux_rdata, 0);
    cyc(); mid();
    check("b_n1_ren", b_mem_ren, 1); check("b_n1_addr", b_mem_addr, 32'h84);
    cyc(); mid();
    cyc();
    b_rst_n = 1'b0;
    mid();
    check("b_n3_auxdone", b_aux_done, 0);
    cyc();
    b_rst_n = 1'b1; b_aux_req = 1'b0;
    mid();
    check("b_rst_auxdone", b_aux_done, 0); check("b_rst_ren", b_mem_ren, 0);
    check("b_rst_wen", b_mem_wen, 0); check("b_rst_rdata", b_aux_rdata, 0);
    cyc(); mid();
    check("b_n5_auxdone", b_aux_done, 0); check("b_n5_ren", b_mem_ren, 0);
    cyc(); mid();
    check("b_n6_auxdone", b_aux_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
